// File: rtl/scan_cmd_mc_ctrl_if.sv
// scan_cmd_mc_ctrl_if: PMT ADC start bus (data = cmd[CMD_W-1:0] + channel mask[8+:CH_NUM], vld qualifier, hold time in ms)
interface scan_cmd_mc_ctrl_if #(
  parameter int HOLD_W = 32
);
  logic [31:0]       pmt_adc_start_data;
  logic              pmt_adc_start_vld;
  logic [HOLD_W-1:0] pmt_adc_start_hold;
  modport master (output pmt_adc_start_data, pmt_adc_start_vld, pmt_adc_start_hold);
  modport slave (input pmt_adc_start_data, pmt_adc_start_vld, pmt_adc_start_hold);
endinterface

// File: rtl/scan_cmd_mc_ctrl.sv
// scan_cmd_mc_ctrl: per-channel IDLE/TIMED/REAL scan FSMs; in: start_if bus, real flag/sel, collision clr; out: cmd/upd/busy/done per channel, collision
module scan_cmd_mc_ctrl #(
  parameter real             TCQ      = 0.1,
  parameter int              CH_NUM   = 3,
  parameter int              CMD_W    = 4,
  parameter int              HOLD_W   = 32,
  parameter int              UNIT_CYC = 100000,
  parameter logic [CMD_W-1:0] REAL_CMD = 4'b0001
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    real_scan_flag_i,
  input  logic [CH_NUM-1:0]       real_scan_sel_i,
  scan_cmd_mc_ctrl_if.slave       start_if,
  input  logic                    collision_clr_i,
  output logic [CH_NUM*CMD_W-1:0] pmt_scan_cmd_o,
  output logic [CH_NUM-1:0]       pmt_scan_upd_o,
  output logic [CH_NUM-1:0]       pmt_scan_busy_o,
  output logic [CH_NUM-1:0]       pmt_scan_done_o,
  output logic                    collision_o
);
  localparam int UW = UNIT_CYC > 1 ? $clog2(UNIT_CYC) : 1;
  typedef enum logic [1:0] {IDLE, TIMED, REAL} st_t;
  logic [2:0] sync_q;
  logic pose, nege, unused_data;
  logic [CH_NUM-1:0] coll_set, mask;
  logic [CMD_W-1:0] cmd_in;
  if (CH_NUM < 1 || CH_NUM > 8 || CMD_W > 8 || TCQ < 0.0) begin : g_bad_param
    $error("scan_cmd_mc_ctrl: unsupported parameter set");
  end
  assign cmd_in = start_if.pmt_adc_start_data[CMD_W-1:0];
  assign mask = start_if.pmt_adc_start_data[8 +: CH_NUM];
  assign unused_data = ^start_if.pmt_adc_start_data;
  assign pose = sync_q[1] & ~sync_q[2];
  assign nege = ~sync_q[1] & sync_q[2];
  always_ff @(posedge clk_i) begin
    sync_q <= rst_n_i ? {sync_q[1:0], real_scan_flag_i} : '0;
    collision_o <= rst_n_i & (|coll_set | (collision_o & ~collision_clr_i));
  end
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    st_t st_q, st_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [HOLD_W-1:0] hold_q, ms_q;
    logic [UW-1:0] unit_q;
    logic start, stop, rp, wrap, expire, coll, upd_q, done_q;
    assign start = start_if.pmt_adc_start_vld & cmd_in[0] & mask[c];
    assign stop = start_if.pmt_adc_start_vld & ~cmd_in[0] & mask[c];
    assign rp = pose & real_scan_sel_i[c];
    assign wrap = unit_q == UW'(UNIT_CYC - 1);
    assign expire = st_q == TIMED && wrap && hold_q != '0 && ms_q == hold_q - 1'b1;
    assign coll_set[c] = coll;
    always_comb begin
      st_d = st_q;
      cmd_d = cmd_q;
      coll = 1'b0;
      case (st_q)
        IDLE: begin
          coll = start & rp;
          st_d = start ? TIMED : rp ? REAL : IDLE;
          cmd_d = start ? cmd_in : rp ? REAL_CMD : cmd_q;
        end
        TIMED: begin
          coll = start | rp;
          st_d = stop | expire ? IDLE : TIMED;
          cmd_d = stop | expire ? '0 : cmd_q;
        end
        default: begin
          coll = start | rp;
          st_d = stop | nege ? IDLE : REAL;
          cmd_d = stop | nege ? '0 : cmd_q;
        end
      endcase
    end
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        st_q <= IDLE;
        cmd_q <= '0;
        hold_q <= '0;
        ms_q <= '0;
        unit_q <= '0;
        upd_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st_q <= st_d;
        cmd_q <= cmd_d;
        upd_q <= cmd_d != cmd_q;
        done_q <= expire;
        hold_q <= st_q == IDLE && st_d == TIMED ? start_if.pmt_adc_start_hold : hold_q;
        unit_q <= st_q == TIMED && st_d == TIMED && !wrap ? unit_q + 1'b1 : '0;
        ms_q <= st_q != TIMED || st_d != TIMED ? '0 : wrap && ms_q != '1 ? ms_q + 1'b1 : ms_q;
      end
    end
    assign pmt_scan_cmd_o[c*CMD_W +: CMD_W] = cmd_q;
    assign pmt_scan_upd_o[c] = upd_q;
    assign pmt_scan_busy_o[c] = st_q != IDLE;
    assign pmt_scan_done_o[c] = done_q;
  end
endmodule

// File: tb/tb_scan_cmd_mc_ctrl.sv
// tb_scan_cmd_mc_ctrl: vector table, directed corner sequences and randomized traffic against a deadline-based reference model
module tb_scan_cmd_mc_ctrl;
  localparam int CH = 3;
  localparam int U = 10;
  logic clk = 1'b0, rst_n, flag, clr;
  logic [CH-1:0] sel, upd, busy, done;
  logic [CH*4-1:0] cmd;
  logic coll;
  int ntot = 0, npass = 0;
  longint cyc = 0;
  bit chk_en = 0;
  scan_cmd_mc_ctrl_if #(.HOLD_W(32)) bus ();
  scan_cmd_mc_ctrl #(.TCQ(0.1), .CH_NUM(CH), .CMD_W(4), .HOLD_W(32), .UNIT_CYC(U), .REAL_CMD(4'b0001)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .real_scan_flag_i(flag), .real_scan_sel_i(sel), .start_if(bus),
    .collision_clr_i(clr), .pmt_scan_cmd_o(cmd), .pmt_scan_upd_o(upd), .pmt_scan_busy_o(busy),
    .pmt_scan_done_o(done), .collision_o(coll));
  always #5 clk = ~clk;
  // reference model: mode 0 idle, 1 timed, 2 real; timed scans end at an absolute deadline cycle
  int mode [CH];
  logic [3:0] mcmd [CH];
  longint mend [CH];
  logic fq [$];
  logic [CH-1:0] e_upd, e_done, e_busy;
  logic [CH*4-1:0] e_cmd;
  logic e_coll;
  always @(posedge clk) begin : model
    logic pose, nege, st, sp, rp, set;
    logic [3:0] old;
    cyc++;
    if (!rst_n) begin
      fq = {1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < CH; i++) begin
        mode[i] = 0;
        mcmd[i] = 4'h0;
        mend[i] = -1;
      end
      e_upd = '0;
      e_done = '0;
      e_coll = 1'b0;
    end else begin
      fq.push_front(flag);
      void'(fq.pop_back());
      pose = fq[2] && !fq[3];
      nege = !fq[2] && fq[3];
      set = 1'b0;
      for (int i = 0; i < CH; i++) begin
        st = bus.pmt_adc_start_vld && bus.pmt_adc_start_data[0] && bus.pmt_adc_start_data[8+i];
        sp = bus.pmt_adc_start_vld && !bus.pmt_adc_start_data[0] && bus.pmt_adc_start_data[8+i];
        rp = pose && sel[i];
        old = mcmd[i];
        e_done[i] = 1'b0;
        if (mode[i] == 0) begin
          if (st) begin
            mode[i] = 1;
            mcmd[i] = bus.pmt_adc_start_data[3:0];
            mend[i] = bus.pmt_adc_start_hold == 0 ? -1 : cyc + longint'(bus.pmt_adc_start_hold) * U;
            set = set | rp;
          end else if (rp) begin
            mode[i] = 2;
            mcmd[i] = 4'b0001;
          end
        end else begin
          set = set | st | rp;
          if (mode[i] == 1 && (sp || cyc == mend[i])) begin
            e_done[i] = cyc == mend[i];
            mode[i] = 0;
            mcmd[i] = 4'h0;
          end else if (mode[i] == 2 && (sp || nege)) begin
            mode[i] = 0;
            mcmd[i] = 4'h0;
          end
        end
        e_upd[i] = mcmd[i] != old;
      end
      e_coll = set || (e_coll && !clr);
    end
    for (int i = 0; i < CH; i++) begin
      e_cmd[i*4 +: 4] = mcmd[i];
      e_busy[i] = mode[i] != 0;
    end
  end
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
  endtask
  always @(negedge clk) if (chk_en) begin
    check("model_cmd", cmd, e_cmd);
    check("model_upd", upd, e_upd);
    check("model_busy", busy, e_busy);
    check("model_done", done, e_done);
    check("model_coll", coll, e_coll);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] h);
    bus.pmt_adc_start_vld = v;
    bus.pmt_adc_start_data = d;
    bus.pmt_adc_start_hold = h;
  endtask
  typedef struct {
    logic v;
    logic [31:0] data;
    logic clr;
    logic [11:0] cmd;
    logic [2:0] busy;
    logic coll;
  } vec_t;
  vec_t tv [10];
  logic [CH-1:0] done_seen;
  initial begin
    tv[0] = '{1'b1, 32'h0000_0101, 1'b0, 12'h001, 3'b001, 1'b0};
    tv[1] = '{1'b1, 32'h0000_0209, 1'b0, 12'h091, 3'b011, 1'b0};
    tv[2] = '{1'b1, 32'h0000_010B, 1'b0, 12'h091, 3'b011, 1'b1};
    tv[3] = '{1'b0, 32'h0000_0000, 1'b1, 12'h091, 3'b011, 1'b0};
    tv[4] = '{1'b1, 32'h0000_0700, 1'b0, 12'h000, 3'b000, 1'b0};
    tv[5] = '{1'b1, 32'h0000_0F0F, 1'b0, 12'hFFF, 3'b111, 1'b0};
    tv[6] = '{1'b1, 32'h0000_0500, 1'b0, 12'h0F0, 3'b010, 1'b0};
    tv[7] = '{1'b1, 32'hFFFF_FA00, 1'b0, 12'h000, 3'b000, 1'b0};
    tv[8] = '{1'b0, 32'h0000_0701, 1'b0, 12'h000, 3'b000, 1'b0};
    tv[9] = '{1'b1, 32'h0000_0003, 1'b0, 12'h000, 3'b000, 1'b0};
    rst_n = 1'b0; flag = 1'b0; sel = '0; clr = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk_en = 1;
    step();
    check("rst_cmd", cmd, 12'h000);
    check("rst_busy", busy, 3'b000);
    check("rst_upd", upd, 3'b000);
    check("rst_done", done, 3'b000);
    check("rst_coll", coll, 1'b0);
    rst_n = 1'b1;
    step();
    // timed scan on ch0+ch1, hold 3 ms
    drive(1'b1, 32'h0000_0301, 32'd3); step(); drive(1'b0, 32'h0, 32'h0);
    check("t1_cmd", cmd, 12'h011);
    check("t1_upd", upd, 3'b011);
    check("t1_busy", busy, 3'b011);
    repeat (29) step();
    check("t1_cmd_held", cmd, 12'h011);
    check("t1_no_early_done", done, 3'b000);
    step();
    check("t1_cmd_end", cmd, 12'h000);
    check("t1_done", done, 3'b011);
    check("t1_upd_end", upd, 3'b011);
    step();
    // hold 0 never times out
    drive(1'b1, 32'h0000_0101, 32'd0); step(); drive(1'b0, 32'h0, 32'h0);
    repeat (1000) step();
    check("t2_busy", busy, 3'b001);
    drive(1'b1, 32'h0000_0100, 32'd0); step(); drive(1'b0, 32'h0, 32'h0);
    check("t2_stop_busy", busy, 3'b000);
    check("t2_stop_cmd", cmd, 12'h000);
    check("t2_no_done", done, 3'b000);
    // real scan on ch2
    flag = 1'b1; sel = 3'b100;
    step(); step();
    check("t3_not_yet", cmd, 12'h000);
    step();
    check("t3_cmd", cmd, 12'h100);
    check("t3_upd", upd, 3'b100);
    sel = 3'b000; flag = 1'b0;
    step(); step();
    check("t3_held", cmd, 12'h100);
    step();
    check("t3_off", cmd, 12'h000);
    check("t3_off_busy", busy, 3'b000);
    // timed start and real pose on ch0 in the same cycle
    flag = 1'b1; sel = 3'b001;
    step(); step();
    drive(1'b1, 32'h0000_0103, 32'd5); step(); drive(1'b0, 32'h0, 32'h0);
    check("t4_cmd", cmd, 12'h003);
    check("t4_coll", coll, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    check("t4_clr", coll, 1'b0);
    drive(1'b1, 32'h0000_0100, 32'd0); step(); drive(1'b0, 32'h0, 32'h0);
    flag = 1'b0; sel = 3'b000;
    repeat (4) step();
    check("t4_idle", cmd, 12'h000);
    // collision set and clear in the same cycle
    drive(1'b1, 32'h0000_0101, 32'd0); step();
    clr = 1'b1; step(); clr = 1'b0; drive(1'b0, 32'h0, 32'h0);
    check("setclr_coll", coll, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    check("setclr_clr", coll, 1'b0);
    drive(1'b1, 32'h0000_0100, 32'd0); step(); drive(1'b0, 32'h0, 32'h0);
    // second start to busy ch1
    drive(1'b1, 32'h0000_0205, 32'd0); step();
    drive(1'b1, 32'h0000_0207, 32'd0); step(); drive(1'b0, 32'h0, 32'h0);
    check("t5_cmd", cmd, 12'h050);
    check("t5_upd", upd, 3'b000);
    check("t5_coll", coll, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    drive(1'b1, 32'h0000_0200, 32'd0); step(); drive(1'b0, 32'h0, 32'h0);
    // reset mid timed scan
    drive(1'b1, 32'h0000_0301, 32'd5); step(); drive(1'b0, 32'h0, 32'h0);
    repeat (10) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t6_cmd", cmd, 12'h000);
    check("t6_busy", busy, 3'b000);
    check("t6_upd", upd, 3'b000);
    check("t6_done", done, 3'b000);
    done_seen = '0;
    repeat (60) begin
      step();
      done_seen = done_seen | done;
    end
    check("t6_no_done", done_seen, 3'b000);
    // vector table, hold 0 so nothing expires
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].v, tv[i].data, 32'd0);
      clr = tv[i].clr;
      step();
      drive(1'b0, 32'h0, 32'h0);
      clr = 1'b0;
      check($sformatf("tv%0d_cmd", i), cmd, tv[i].cmd);
      check($sformatf("tv%0d_busy", i), busy, tv[i].busy);
      check($sformatf("tv%0d_coll", i), coll, tv[i].coll);
    end
    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom(), $urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) flag = ~flag;
      sel = 3'($urandom_range(0, 7));
      clr = $urandom_range(0, 7) == 0;
      rst_n = $urandom_range(0, 499) != 0;
      step();
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk_en = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
